// File: rtl/hart_debug_ctl_pkg.sv
// Shared debug definitions for the hart debug controller: FSM state
// encoding, halt cause codes and the halt-cause priority helper.
package hart_debug_ctl_pkg;

    typedef enum logic [2:0] {
        ST_RUNNING  = 3'd0,
        ST_HALTING  = 3'd1,
        ST_HALTED   = 3'd2,
        ST_ACCESS   = 3'd3,
        ST_RESUMING = 3'd4,
        ST_STEPPING = 3'd5
    } dbg_state_e;

    typedef logic [2:0] cause_t;

    localparam cause_t CAUSE_NONE    = 3'd0;
    localparam cause_t CAUSE_EBREAK  = 3'd1;
    localparam cause_t CAUSE_TRIGGER = 3'd2;
    localparam cause_t CAUSE_HALTREQ = 3'd3;
    localparam cause_t CAUSE_STEP    = 3'd4;

    // Priority on a halting boundary: trigger > ebreak > haltreq > step.
    function automatic cause_t halt_cause(input logic trigger,
                                          input logic ebreak,
                                          input logic haltreq);
        if (trigger)      return CAUSE_TRIGGER;
        else if (ebreak)  return CAUSE_EBREAK;
        else if (haltreq) return CAUSE_HALTREQ;
        else              return CAUSE_STEP;
    endfunction

endpackage

// File: rtl/hart_debug_ctl.sv
// Hart debug controller: halt/resume/single-step sequencing plus abstract
// GPR access through a register-file takeover port.
// Build option: define RV_DEBUG_STEP_EN to enable single-step (STEPPING
// state and the step input); without it step is ignored and every resume
// returns straight to RUNNING.
module hart_debug_ctl
    import hart_debug_ctl_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             haltreq,
    input  logic             resumereq,
    input  logic             step,
    input  logic             boundary,
    input  logic             ebreak_dbg,
    input  logic             trigger_hit,
    output logic             halted,
    output logic             running,
    output logic             resumeack,
    output logic             core_stall,
    output logic             dpc_we,
    output logic [2:0]       cause,
    output logic             resume_pc_we,
    input  logic             ar_req,
    input  logic             ar_write,
    input  logic [4:0]       ar_regno,
    input  logic [Width-1:0] ar_wdata,
    output logic [Width-1:0] ar_rdata,
    output logic             ar_done,
    output logic             ar_err,
    output logic             rf_own,
    output logic [4:0]       rf_addr,
    output logic [Width-1:0] rf_wdata,
    output logic             rf_we,
    input  logic [Width-1:0] rf_rdata
);

    dbg_state_e       state_q, state_d;
    cause_t           cause_q, cause_d;
    logic             acc_write_q;
    logic [4:0]       acc_regno_q;
    logic [Width-1:0] acc_wdata_q;
    logic [Width-1:0] ar_rdata_q;
    logic             ar_done_q;
    logic             ar_err_q;

    logic step_en;
`ifdef RV_DEBUG_STEP_EN
    assign step_en = step;
`else
    logic unused_step;
    assign step_en     = 1'b0;
    assign unused_step = step;
`endif

    // A command is accepted only from HALTED; anywhere else it is rejected.
    logic acc_start, acc_end, bad_req;
    assign acc_start = (state_q == ST_HALTED) && ar_req;
    assign acc_end   = (state_q == ST_ACCESS);
    assign bad_req   = ar_req && (state_q != ST_HALTED);

    // Next-state, halt cause and the same-cycle dpc write strobe.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cause_d = cause_q;
        dpc_we  = 1'b0;
        case (state_q)
            ST_RUNNING: begin
                if (boundary && (trigger_hit || ebreak_dbg)) begin
                    state_d = ST_HALTED;
                    dpc_we  = 1'b1;
                    cause_d = halt_cause(trigger_hit, ebreak_dbg, haltreq);
                end else if (haltreq) begin
                    state_d = ST_HALTING;
                end
            end
            ST_HALTING: begin
                // The request is latched by being here; haltreq may already be low.
                if (boundary) begin
                    state_d = ST_HALTED;
                    dpc_we  = 1'b1;
                    cause_d = halt_cause(trigger_hit, ebreak_dbg, 1'b1);
                end
            end
            ST_HALTED: begin
                // A command wins over a simultaneous resume; the resume is dropped.
                if (ar_req)         state_d = ST_ACCESS;
                else if (resumereq) state_d = ST_RESUMING;
            end
            ST_ACCESS: begin
                state_d = ST_HALTED;
            end
            ST_RESUMING: begin
                state_d = step_en ? ST_STEPPING : ST_RUNNING;
            end
            ST_STEPPING: begin
                if (boundary) begin
                    state_d = ST_HALTED;
                    dpc_we  = 1'b1;
                    cause_d = halt_cause(trigger_hit, ebreak_dbg, haltreq);
                end
            end
            default: begin
                state_d = ST_RUNNING;
            end
        endcase
    end

    // State, cause, captured command and the registered command response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUNNING;
            cause_q     <= CAUSE_NONE;
            acc_write_q <= 1'b0;
            acc_regno_q <= 5'd0;
            acc_wdata_q <= '0;
            ar_rdata_q  <= '0;
            ar_done_q   <= 1'b0;
            ar_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            state_q   <= state_d;
            cause_q   <= cause_d;
            ar_done_q <= acc_end || bad_req;
            ar_err_q  <= bad_req;
            if (acc_start) begin
                acc_write_q <= ar_write;
                acc_regno_q <= ar_regno;
                acc_wdata_q <= ar_wdata;
            end
            if (acc_end && !acc_write_q) begin
                ar_rdata_q <= rf_rdata;
            end
        end
    end

    assign halted       = (state_q == ST_HALTED) || (state_q == ST_ACCESS) ||
                          (state_q == ST_RESUMING);
    assign core_stall   = halted;
    assign running      = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);
    assign resumeack    = (state_q == ST_RESUMING);
    assign resume_pc_we = (state_q == ST_RESUMING);
    assign cause        = cause_q;

    assign rf_own   = acc_end;
    assign rf_addr  = rf_own ? acc_regno_q : 5'd0;
    assign rf_wdata = rf_own ? acc_wdata_q : '0;
    // x0 is hardwired: the write completes normally but never reaches the file.
    assign rf_we    = rf_own && acc_write_q && (acc_regno_q != 5'd0);

    assign ar_rdata = ar_rdata_q;
    assign ar_done  = ar_done_q;
    assign ar_err   = ar_err_q;

endmodule

// File: tb/tb_hart_debug_ctl.sv
// Testbench for hart_debug_ctl: directed stimulus, a transaction-level
// model compared on every cycle, and hand-computed literal checks.
module tb_hart_debug_ctl;

`ifdef RV_DEBUG_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic        haltreq, resumereq, step, boundary, ebreak_dbg, trigger_hit;
    logic        halted, running, resumeack, core_stall, dpc_we, resume_pc_we;
    logic [2:0]  cause;
    logic        ar_req, ar_write;
    logic [4:0]  ar_regno;
    logic [31:0] ar_wdata, ar_rdata;
    logic        ar_done, ar_err;
    logic        rf_own, rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata, rf_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    hart_debug_ctl #(.Width(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .haltreq(haltreq), .resumereq(resumereq), .step(step),
        .boundary(boundary), .ebreak_dbg(ebreak_dbg), .trigger_hit(trigger_hit),
        .halted(halted), .running(running), .resumeack(resumeack),
        .core_stall(core_stall), .dpc_we(dpc_we), .cause(cause),
        .resume_pc_we(resume_pc_we),
        .ar_req(ar_req), .ar_write(ar_write), .ar_regno(ar_regno), .ar_wdata(ar_wdata),
        .ar_rdata(ar_rdata), .ar_done(ar_done), .ar_err(ar_err),
        .rf_own(rf_own), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .rf_rdata(rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] gpr_init(input int i);
        return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
    endfunction

    // Core register-file stub that the controller takes over.
    logic [31:0] rf_mem [32];
    assign rf_rdata = rf_mem[rf_addr];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= gpr_init(i);
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_wdata;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Debugger-view model: is the hart halted, is a halt pending, is it
    // running a single step, plus the pending command and response pulses.
    bit          m_halted, m_halt_pending, m_stepping, m_resume_now;
    bit          m_acc_active, m_acc_write, m_done, m_err;
    logic [4:0]  m_acc_regno;
    logic [31:0] m_acc_wdata, m_rdata;
    logic [2:0]  m_cause;
    logic [31:0] m_gpr [32];

    task automatic model_reset();
        m_halted = 0; m_halt_pending = 0; m_stepping = 0; m_resume_now = 0;
        m_acc_active = 0; m_acc_write = 0; m_done = 0; m_err = 0;
        m_acc_regno = 0; m_acc_wdata = 0; m_rdata = 0; m_cause = 0;
        for (int i = 0; i < 32; i++) m_gpr[i] = gpr_init(i);
    endtask

    always @(negedge clk) begin : model_cmp
        logic exp_dpc;
        logic done_nx, err_nx;
        if (!rst_n) model_reset();
        exp_dpc = !m_halted && boundary &&
                  (m_halt_pending || m_stepping || trigger_hit || ebreak_dbg);
        check("m_halted",     halted,       m_halted);
        check("m_stall",      core_stall,   m_halted);
        check("m_running",    running,      !m_halted && !m_halt_pending);
        check("m_resumeack",  resumeack,    m_resume_now);
        check("m_resume_pc",  resume_pc_we, m_resume_now);
        check("m_dpc_we",     dpc_we,       exp_dpc);
        check("m_cause",      cause,        m_cause);
        check("m_rf_own",     rf_own,       m_acc_active);
        check("m_rf_addr",    rf_addr,      m_acc_active ? m_acc_regno : 5'd0);
        check("m_rf_wdata",   rf_wdata,     m_acc_active ? m_acc_wdata : 32'd0);
        check("m_rf_we",      rf_we,        m_acc_active && m_acc_write && (m_acc_regno != 0));
        check("m_ar_done",    ar_done,      m_done);
        check("m_ar_err",     ar_err,       m_err);
        check("m_ar_rdata",   ar_rdata,     m_rdata);
        if (rst_n) begin
            done_nx = 1'b0;
            err_nx  = 1'b0;
            if (!m_halted) begin
                err_nx  = ar_req;
                done_nx = ar_req;
                if (exp_dpc) begin
                    m_cause = trigger_hit ? 3'd2 : ebreak_dbg ? 3'd1 :
                              (m_halt_pending || haltreq) ? 3'd3 : 3'd4;
                    m_halted = 1; m_halt_pending = 0; m_stepping = 0;
                end else if (haltreq && !m_stepping) begin
                    m_halt_pending = 1;
                end
            end else if (m_acc_active) begin
                if (m_acc_write) begin
                    if (m_acc_regno != 0) m_gpr[m_acc_regno] = m_acc_wdata;
                end else begin
                    m_rdata = m_gpr[m_acc_regno];
                end
                m_acc_active = 0;
                done_nx = 1'b1;
                err_nx  = ar_req;
            end else if (m_resume_now) begin
                m_resume_now = 0;
                m_halted     = 0;
                m_stepping   = STEP_EN && step;
                err_nx  = ar_req;
                done_nx = ar_req;
            end else if (ar_req) begin
                m_acc_active = 1;
                m_acc_write  = ar_write;
                m_acc_regno  = ar_regno;
                m_acc_wdata  = ar_wdata;
            end else if (resumereq) begin
                m_resume_now = 1;
            end
            m_done = done_nx;
            m_err  = err_nx;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0; haltreq = 0; resumereq = 0; step = 0; boundary = 0;
        ebreak_dbg = 0; trigger_hit = 0; ar_req = 0; ar_write = 0;
        ar_regno = 0; ar_wdata = 0;
        tick(); tick();
        @(negedge clk);
        check("reset_running", running, 1);
        check("reset_halted",  halted, 0);
        check("reset_cause",   cause, 0);
        check("reset_stall",   core_stall, 0);
        tick(); rst_n = 1; tick();

        // haltreq, boundary three cycles later
        haltreq = 1; tick(); tick(); tick(); boundary = 1;
        @(negedge clk);
        check("halt_dpc_we", dpc_we, 1);
        check("halting_not_running", running, 0);
        tick(); boundary = 0; haltreq = 0;
        @(negedge clk);
        check("halt_halted", halted, 1);
        check("halt_cause",  cause, 3);
        check("halt_dpc_pulse", dpc_we, 0);

        // haltreq while halted is ignored
        haltreq = 1; tick(); tick(); haltreq = 0;
        @(negedge clk);
        check("halted_haltreq_cause", cause, 3);

        // write x5
        ar_req = 1; ar_write = 1; ar_regno = 5; ar_wdata = 32'hDEADBEEF;
        tick(); ar_req = 0;
        @(negedge clk);
        check("wr_rf_we",    rf_we, 1);
        check("wr_rf_addr",  rf_addr, 5);
        check("wr_rf_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check("wr_done", ar_done, 1);
        check("wr_err",  ar_err, 0);
        check("wr_we_pulse", rf_we, 0);

        // read x5 with a simultaneous resumereq (resume dropped)
        ar_req = 1; ar_write = 0; resumereq = 1;
        tick(); ar_req = 0; resumereq = 0;
        @(negedge clk);
        check("rd_rf_own", rf_own, 1);
        tick();
        @(negedge clk);
        check("rd_done",  ar_done, 1);
        check("rd_rdata", ar_rdata, 32'hDEADBEEF);
        tick(); tick();
        @(negedge clk);
        check("race_still_halted", halted, 1);

        // write to x0: completes, no rf_we, no error
        ar_req = 1; ar_write = 1; ar_regno = 0; ar_wdata = 32'h12345678;
        tick(); ar_req = 0;
        @(negedge clk);
        check("x0_no_we", rf_we, 0);
        tick();
        @(negedge clk);
        check("x0_done", ar_done, 1);
        check("x0_err",  ar_err, 0);
        check("rdata_held", ar_rdata, 32'hDEADBEEF);

        // resume
        resumereq = 1; tick(); resumereq = 0;
        @(negedge clk);
        check("resume_ack", resumeack, 1);
        check("resume_pc_we", resume_pc_we, 1);
        tick();
        @(negedge clk);
        check("resumed_running", running, 1);
        check("resumed_cause_held", cause, 3);

        // resumereq while running is ignored
        resumereq = 1; tick(); resumereq = 0;
        @(negedge clk);
        check("run_resume_ignored", resumeack, 0);

        // trigger and ebreak on the same boundary
        tick(); boundary = 1; trigger_hit = 1; ebreak_dbg = 1;
        @(negedge clk);
        check("trig_dpc_we", dpc_we, 1);
        tick(); boundary = 0; trigger_hit = 0; ebreak_dbg = 0;
        @(negedge clk);
        check("trig_halted", halted, 1);
        check("trig_cause",  cause, 2);

        // resume, then ebreak alone
        resumereq = 1; tick(); resumereq = 0; tick();
        boundary = 1; ebreak_dbg = 1;
        @(negedge clk);
        check("ebrk_dpc_we", dpc_we, 1);
        tick(); boundary = 0; ebreak_dbg = 0;
        @(negedge clk);
        check("ebrk_cause", cause, 1);

        // single step
        step = 1; resumereq = 1; tick(); resumereq = 0;
        @(negedge clk);
        check("step_resumeack", resumeack, 1);
        tick();
        @(negedge clk);
        check("step_running", running, 1);
        tick(); tick(); boundary = 1;
        @(negedge clk);
        check("step_dpc_we", dpc_we, STEP_EN);
        tick(); boundary = 0; step = 0;
        @(negedge clk);
        check("step_halted", halted, STEP_EN);
        check("step_cause",  cause, STEP_EN ? 3'd4 : 3'd1);
        if (STEP_EN) begin
            resumereq = 1; tick(); resumereq = 0; tick();
        end

        // command while running
        ar_req = 1; ar_write = 0; ar_regno = 3; tick(); ar_req = 0;
        @(negedge clk);
        check("err_err",  ar_err, 1);
        check("err_done", ar_done, 1);
        check("err_running", running, 1);

        // reset in the middle of an access
        haltreq = 1; tick(); boundary = 1; tick(); boundary = 0; haltreq = 0;
        ar_req = 1; ar_write = 0; ar_regno = 7; tick(); ar_req = 0;
        rst_n = 0;
        @(negedge clk);
        check("rst_running", running, 1);
        check("rst_rf_own",  rf_own, 0);
        check("rst_done",    ar_done, 0);
        check("rst_cause",   cause, 0);
        check("rst_rdata",   ar_rdata, 0);
        tick(); rst_n = 1;
        @(negedge clk);
        check("rst_no_done", ar_done, 0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
